// File: rtl/ex_muldiv_pkg.sv
// Shared decode for the RV64M multiply/divide sequencer: ALU op codes,
// FSM state encoding and op-class helpers.
package ex_muldiv_pkg;

  // M-extension ALU codes (the non-M ALU ops occupy codes below 16)
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;
  localparam logic [4:0] ALU_MULW   = 5'd24;
  localparam logic [4:0] ALU_DIVW   = 5'd25;
  localparam logic [4:0] ALU_DIVUW  = 5'd26;
  localparam logic [4:0] ALU_REMW   = 5'd27;
  localparam logic [4:0] ALU_REMUW  = 5'd28;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  function automatic logic is_md(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU,
                      ALU_REM, ALU_REMU, ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic is_mul(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW};
  endfunction

  function automatic logic is_w(input logic [4:0] op);
    return op inside {ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW};
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    return op inside {ALU_REM, ALU_REMU, ALU_REMW, ALU_REMUW};
  endfunction

  // Signed divide/remainder (operand magnitudes and sign fix-up needed)
  function automatic logic is_sdiv(input logic [4:0] op);
    return op inside {ALU_DIV, ALU_REM, ALU_DIVW, ALU_REMW};
  endfunction

endpackage

// File: rtl/ex_muldiv_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module ex_muldiv_divstep
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  // Partial remainder can reach 2*divisor-1, so one extra bit is carried;
  // bit XLEN of the difference is the borrow.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_i};

  // Restore (keep shifted value) when the subtraction borrows
  always_comb begin
    if (diff[XLEN]) begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV64M multi-cycle sequencer beside the ex-stage ALU. Multiplies take a
// fixed MUL_LATENCY cycles; divides iterate one quotient bit per cycle, with
// divide-by-zero and signed overflow short-circuited straight to DONE.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [4:0]      aluop_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            ready_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int HW    = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN) + 1;

  function automatic logic [XLEN-1:0] sext_w(input logic [HW-1:0] v);
    return {{HW{v[HW-1]}}, v};
  endfunction

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [4:0]       rdo_q, rdo_d;
  // Datapath: opa = multiplicand / dividend-quotient shifter, opb = multiplier / divisor
  logic [4:0]       op_q, op_d, rd_q, rd_d;
  logic [XLEN-1:0]  opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
  logic             negq_q, negq_d, negr_q, negr_d;

  logic start;
  assign start = valid_i & is_md(aluop_i) & (state_q == MD_IDLE) & ~flush_i;

  // Divide operand preparation at accept time (W ops use the low half)
  logic            w_in, sgn_in, div_zero, div_ovf;
  logic [XLEN-1:0] dvd_in, dvs_in, min_v, mag_a, mag_b, quo_init, zero_res, ovf_res;

  assign w_in     = is_w(aluop_i);
  assign sgn_in   = is_sdiv(aluop_i);
  assign dvd_in   = !w_in ? operand1_i :
                    sgn_in ? sext_w(operand1_i[HW-1:0]) : {{HW{1'b0}}, operand1_i[HW-1:0]};
  assign dvs_in   = !w_in ? operand2_i :
                    sgn_in ? sext_w(operand2_i[HW-1:0]) : {{HW{1'b0}}, operand2_i[HW-1:0]};
  assign min_v    = w_in ? sext_w({1'b1, {(HW-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (dvs_in == '0);
  assign div_ovf  = sgn_in && (dvd_in == min_v) && (dvs_in == '1);
  assign mag_a    = (sgn_in && dvd_in[XLEN-1]) ? -dvd_in : dvd_in;
  assign mag_b    = (sgn_in && dvs_in[XLEN-1]) ? -dvs_in : dvs_in;
  // W dividends are left-aligned so the MSB-first step works on the low half
  assign quo_init = w_in ? {mag_a[HW-1:0], {HW{1'b0}}} : mag_a;
  assign zero_res = is_rem(aluop_i) ? (w_in ? sext_w(dvd_in[HW-1:0]) : dvd_in) : '1;
  assign ovf_res  = is_rem(aluop_i) ? '0 : dvd_in;

  // Multiplier: operands sign- or zero-extended to 2*XLEN, low 2*XLEN bits of product
  logic            mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0] mul_res;

  assign mul_sa  = (op_q == ALU_MULH) || (op_q == ALU_MULHSU);
  assign mul_sb  = (op_q == ALU_MULH);
  assign mul_a   = {{XLEN{mul_sa & opa_q[XLEN-1]}}, opa_q};
  assign mul_b   = {{XLEN{mul_sb & opb_q[XLEN-1]}}, opb_q};
  assign prod    = mul_a * mul_b;
  assign mul_res = (op_q == ALU_MUL)  ? prod[XLEN-1:0] :
                   (op_q == ALU_MULW) ? sext_w(prod[HW-1:0]) : prod[2*XLEN-1:XLEN];

  // Divider step and final sign fix-up
  logic [XLEN-1:0] step_rem, step_quo, q_raw, q_fix, r_fix, fix_sel, fix_res;

  ex_muldiv_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_i (rem_q),
    .quo_i (opa_q),
    .dvs_i (opb_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign q_raw   = is_w(op_q) ? {{HW{1'b0}}, opa_q[HW-1:0]} : opa_q;
  assign q_fix   = negq_q ? -q_raw : q_raw;
  assign r_fix   = negr_q ? -rem_q : rem_q;
  assign fix_sel = is_rem(op_q) ? r_fix : q_fix;
  assign fix_res = is_w(op_q) ? sext_w(fix_sel[HW-1:0]) : fix_sel;

  // Next-state, counter and datapath load/iterate logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rdo_d   = rdo_q;
    op_d    = op_q;
    rd_d    = rd_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          op_d = aluop_i;
          rd_d = rd_i;
          if (is_mul(aluop_i)) begin
            state_d = MD_MUL;
            cnt_d   = CNT_W'(MUL_LATENCY);
            opa_d   = operand1_i;
            opb_d   = operand2_i;
          end else if (div_zero) begin
            state_d = MD_DONE;
            res_d   = zero_res;
            rdo_d   = rd_i;
          end else if (div_ovf) begin
            state_d = MD_DONE;
            res_d   = ovf_res;
            rdo_d   = rd_i;
          end else begin
            state_d = MD_DIV;
            cnt_d   = w_in ? CNT_W'(HW) : CNT_W'(XLEN);
            opa_d   = quo_init;
            opb_d   = mag_b;
            rem_d   = '0;
            negq_d  = sgn_in & (dvd_in[XLEN-1] ^ dvs_in[XLEN-1]);
            negr_d  = sgn_in & dvd_in[XLEN-1];
          end
        end
      end
      MD_MUL: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_DONE;
          cnt_d   = '0;
          res_d   = mul_res;
          rdo_d   = rd_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MD_DIV: begin
        opa_d = step_quo;
        rem_d = step_rem;
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MD_FIX: begin
        state_d = MD_DONE;
        res_d   = fix_res;
        rdo_d   = rd_q;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Control and architecturally visible result registers; flush acts like reset
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
    end
  end

  // Datapath registers: only meaningful once loaded by an accepted op
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    rd_q   <= rd_d;
    opa_q  <= opa_d;
    opb_q  <= opb_d;
    rem_q  <= rem_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign stall_o  = start | (state_q inside {MD_MUL, MD_DIV, MD_FIX});
  assign ready_o  = (state_q == MD_IDLE);
  assign valid_o  = (state_q == MD_DONE);
  assign result_o = res_q;
  assign rd_o     = rdo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: each issued op pushes its expected result,
// rd and completion cycle; a monitor pops and compares on every valid_o.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int MUL_LATENCY = 2;
  localparam int LAT_MUL  = MUL_LATENCY + 1;
  localparam int LAT_DIV  = 66;
  localparam int LAT_DIVW = 34;
  localparam int LAT_SPC  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [4:0]  aluop_i = '0;
  logic [4:0]  rd_i = '0;
  logic [63:0] operand1_i = '0;
  logic [63:0] operand2_i = '0;
  logic        stall_o, ready_o, valid_o;
  logic [63:0] result_o;
  logic [4:0]  rd_o;

  ex_muldiv #(.XLEN(64), .MUL_LATENCY(MUL_LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .aluop_i    (aluop_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .rd_i       (rd_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rd_o       (rd_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && valid_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d result=%h rd=%0d", cyc, result_o, rd_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result_o !== e.res || rd_o !== e.rd) begin
          errors++;
          $display("FAIL result rd=%0d got %h/%0d expected %h/%0d", e.rd, result_o, rd_o, e.res, e.rd);
        end
        checks++;
        if (cyc !== e.due) begin
          errors++;
          $display("FAIL latency rd=%0d got cycle %0d expected %0d", e.rd, cyc, e.due);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Drive one op in the current cycle (called just after a posedge); returns
  // stall_o sampled in that cycle and the accept cycle number.
  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input logic [63:0] exp, input int lat,
                       input bit push, output logic stall_t, output int t);
    valid_i = 1'b1; aluop_i = op; operand1_i = a; operand2_i = b; rd_i = rd;
    t = cyc;
    if (push) sb.push_back('{exp, rd, cyc + lat});
    @(negedge clk);
    stall_t = stall_o;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Wait (bounded) until every pushed expectation has been consumed
  task automatic wait_done();
    int i;
    i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (sb.size() != 0 && i < 200);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL wait_timeout pending=%0d expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b expected 0", valid_o); end
    checks++; if (result_o !== '0)   begin errors++; $display("FAIL reset_result got %h expected 0", result_o); end
    checks++; if (rd_o !== '0)       begin errors++; $display("FAIL reset_rd got %0d expected 0", rd_o); end
    checks++; if (stall_o !== 1'b0)  begin errors++; $display("FAIL reset_stall got %b expected 0", stall_o); end
    checks++; if (ready_o !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b expected 1", ready_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    logic st; int t; int n; logic last;
    issue(ALU_DIV, 64'd100, 64'd7, 5'd3, 64'd14, LAT_DIV, 1'b1, st, t);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL div_stall_T got %b expected 1", st); end
    n = 0; last = 1'b0;
    for (int i = 1; i <= LAT_DIV; i++) begin
      @(negedge clk);
      if (stall_o === 1'b1) n++;
      last = stall_o;
    end
    checks++; if (n !== 65) begin errors++; $display("FAIL div_stall_cycles got %0d expected 65", n); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL div_stall_done got %b expected 0", last); end
    wait_done();
    issue(ALU_REM, 64'd100, 64'd7, 5'd4, 64'd2, LAT_DIV, 1'b1, st, t);
    wait_done();
  endtask

  task automatic test_div_zero();
    logic st; int t;
    issue(ALU_DIVU, 64'd5, 64'd0, 5'd5, '1, LAT_SPC, 1'b1, st, t);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL divz_stall_T got %b expected 1", st); end
    @(negedge clk);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL divz_stall_T1 got %b expected 0", stall_o); end
    wait_done();
    issue(ALU_REMU, 64'd5, 64'd0, 5'd6, 64'd5, LAT_SPC, 1'b1, st, t);
    wait_done();
  endtask

  task automatic test_overflow();
    logic st; int t;
    issue(ALU_DIV, 64'h8000_0000_0000_0000, '1, 5'd7, 64'h8000_0000_0000_0000, LAT_SPC, 1'b1, st, t);
    wait_done();
    issue(ALU_REM, 64'h8000_0000_0000_0000, '1, 5'd8, 64'd0, LAT_SPC, 1'b1, st, t);
    wait_done();
  endtask

  task automatic test_mul();
    logic st; int t;
    issue(ALU_MULH, '1, '1, 5'd9, 64'd0, LAT_MUL, 1'b1, st, t);
    wait_done();
    issue(ALU_MULHU, '1, 64'd2, 5'd10, 64'd1, LAT_MUL, 1'b1, st, t);
    wait_done();
    issue(ALU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd11, 64'hFFFF_FFFF_FFFF_FFF4, LAT_MUL, 1'b1, st, t);
    wait_done();
  endtask

  task automatic test_word();
    logic st; int t;
    issue(ALU_DIVW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD, LAT_DIVW, 1'b1, st, t);
    wait_done();
    issue(ALU_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd13, '1, LAT_DIVW, 1'b1, st, t);
    wait_done();
    issue(ALU_MULW, 64'h0001_0000_0000_8000, 64'h0000_0000_0001_0000, 5'd14,
          64'hFFFF_FFFF_8000_0000, LAT_MUL, 1'b1, st, t);
    wait_done();
  endtask

  task automatic test_back_to_back();
    logic st; int t;
    issue(ALU_MUL, 64'd6, 64'd7, 5'd15, 64'd42, LAT_MUL, 1'b1, st, t);
    // Ops presented while busy must be ignored
    valid_i = 1'b1; aluop_i = ALU_DIVU; operand1_i = 64'd9; operand2_i = 64'd3; rd_i = 5'd16;
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_done();
    // Non-M op from idle is ignored
    valid_i = 1'b1; aluop_i = 5'd0; rd_i = 5'd17;
    @(negedge clk);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL nonm_stall got %b expected 0", stall_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL nonm_ready got %b expected 1", ready_o); end
    // Accept the cycle right after DONE
    issue(ALU_DIVU, 64'd9, 64'd3, 5'd18, 64'd3, LAT_DIV, 1'b1, st, t);
    wait_done();
    issue(ALU_MUL, 64'd11, 64'd11, 5'd19, 64'd121, LAT_MUL, 1'b1, st, t);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL accept_after_done got %b expected 1", st); end
    wait_done();
  endtask

  task automatic test_random();
    logic st; int t;
    logic [63:0] a, b, e;
    logic [127:0] p;
    logic signed [63:0] sa, sbv;
    logic [4:0] op;
    int lat;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = ({$urandom, $urandom} >> $urandom_range(0, 60)) | 64'd1;
      sa = a; sbv = b;
      case (i % 4)
        0: begin op = ALU_DIVU;  e = a / b; lat = LAT_DIV; end
        1: begin op = ALU_REMU;  e = a % b; lat = LAT_DIV; end
        2: begin op = ALU_MULHU; p = {64'd0, a} * {64'd0, b}; e = p[127:64]; lat = LAT_MUL; end
        default: begin op = ALU_DIV; e = sa / sbv; lat = LAT_DIV; end
      endcase
      issue(op, a, b, 5'(20 + i), e, lat, 1'b1, st, t);
      wait_done();
    end
  endtask

  task automatic test_flush();
    logic st; int t;
    issue(ALU_DIV, 64'd1000, 64'd3, 5'd28, 64'd0, LAT_DIV, 1'b0, st, t);
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %b expected 1", ready_o); end
    checks++; if (result_o !== '0) begin errors++; $display("FAIL flush_result got %h expected 0", result_o); end
    issue(ALU_MUL, 64'd7, 64'd8, 5'd29, 64'd56, LAT_MUL, 1'b1, st, t);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL flush_new_accept got %b expected 1", st); end
    wait_done();
  endtask

  task automatic test_rst_mid();
    logic st; int t;
    issue(ALU_MUL, 64'd5, 64'd5, 5'd30, 64'd0, LAT_MUL, 1'b0, st, t);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b expected 0", valid_o); end
    checks++; if (result_o !== '0)  begin errors++; $display("FAIL rstmid_result got %h expected 0", result_o); end
    checks++; if (rd_o !== '0)      begin errors++; $display("FAIL rstmid_rd got %0d expected 0", rd_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b expected 0", stall_o); end
    rst = 1'b0;
    @(posedge clk); #1;
    issue(ALU_MULHSU, '1, 64'd2, 5'd31, '1, LAT_MUL, 1'b1, st, t);
    wait_done();
  endtask

  initial begin
    test_reset();
    test_div();
    test_div_zero();
    test_overflow();
    test_mul();
    test_word();
    test_back_to_back();
    test_random();
    test_flush();
    test_rst_mid();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
